// File: rtl/sprite_mem_pkg.sv
// -----------------------------------------------------------------------------
// sprite_mem_pkg
// Shared definitions for the sprite attribute RAM and its port arbiter:
//   - attribute word addresses used by the sprite controllers
//   - animation frame codes stored at SPRITE_FRAME
//   - arbiter FSM state encoding
// No ports (package).
// -----------------------------------------------------------------------------
package sprite_mem_pkg;

  // Attribute word addresses inside the sprite attribute RAM.
  localparam logic [15:0] SPRITE_X     = 16'h1000;
  localparam logic [15:0] SPRITE_Y     = 16'h1001;
  localparam logic [15:0] SPRITE_FRAME = 16'h1002;

  // Animation frame codes held in the SPRITE_FRAME word.
  typedef enum logic [1:0] {
    STANDING   = 2'd0,
    WALK_START = 2'd1,
    WALK_MID   = 2'd2,
    WALK_END   = 2'd3
  } frame_code_t;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GRANT  = 2'd1,
    ARB_LOCKED = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin winner selection. The search starts at ptr and
// wraps modulo NUM_REQ; the first set request bit wins.
// Ports:
//   req    in  NUM_REQ  candidate request vector
//   ptr    in  IDX_W    index searched first
//   grant  out NUM_REQ  one-hot winner (zero when no request)
//   winner out IDX_W    winner index (zero when no request)
//   found  out 1        at least one request was set
// -----------------------------------------------------------------------------
module rr_pick
  import sprite_mem_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   winner,
  output logic               found
);

  logic [IDX_W:0] pos_s;
  logic           hit_s;

  // Scan NUM_REQ positions from ptr with wrap; the first hit freezes the result.
  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    pos_s  = '0;
    hit_s  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos_s  = {1'b0, ptr} + (IDX_W + 1)'(k);
      pos_s  = (pos_s >= (IDX_W + 1)'(NUM_REQ)) ? (pos_s - (IDX_W + 1)'(NUM_REQ)) : pos_s;
      hit_s  = !found && req[pos_s[IDX_W-1:0]];
      winner = hit_s ? pos_s[IDX_W-1:0] : winner;
      grant  = hit_s ? (NUM_REQ'(1) << pos_s[IDX_W-1:0]) : grant;
      found  = found | hit_s;
    end
  end

endmodule

// File: rtl/sprite_mem_arbiter.sv
// -----------------------------------------------------------------------------
// sprite_mem_arbiter
// Arbitrates the single port of the sprite attribute RAM among NUM_REQ sprite
// controllers. Grants are registered and round-robin; a requester may hold the
// port with req_lock for up to LOCK_MAX consecutive cycles, after which the
// lock is force-released and lock_timeout pulses. Reads return one cycle after
// the access, straight from the synchronous RAM.
// Ports:
//   clk, reset     clock; synchronous active-high reset
//   req            per-requester request, held until granted
//   req_lock       keep the grant after the current cycle
//   req_we         1 = write, 0 = read
//   req_addr       flattened addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata      flattened write data, same packing
//   gnt            registered one-hot grant (or zero)
//   rdata          read data, valid while any rvalid bit is set
//   rvalid         one-hot read-return strobe
//   lock_timeout   one-cycle pulse after a forced lock release
//   mem_addr/mem_wdata/mem_we  RAM port
//   mem_rdata      RAM read data, valid one cycle after the address
// -----------------------------------------------------------------------------
module sprite_mem_arbiter
  import sprite_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int LOCK_MAX   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           req_lock,
  input  logic [NUM_REQ-1:0]           req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic [NUM_REQ-1:0]           rvalid,
  output logic                         lock_timeout,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_wdata,
  output logic                         mem_we,
  input  logic [DATA_WIDTH-1:0]        mem_rdata
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int HOLD_W = $clog2(LOCK_MAX) + 1;

  // Saturating increment so the hold counter can never wrap back to zero.
  function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] v);
    return (v == {HOLD_W{1'b1}}) ? v : (v + HOLD_W'(1));
  endfunction

  arb_state_t          state_r, state_s;
  logic [NUM_REQ-1:0]  gnt_r, gnt_s;
  logic [IDX_W-1:0]    idx_r, idx_s;
  logic [IDX_W-1:0]    ptr_r, ptr_s;
  logic [HOLD_W-1:0]   hold_cnt_r, hold_s;
  logic                lock_timeout_r, timeout_s;
  logic [NUM_REQ-1:0]  rvalid_r;

  logic [IDX_W-1:0]    idx_inc_s;
  logic [NUM_REQ-1:0]  pick_req_s;
  logic [IDX_W-1:0]    pick_ptr_s;
  logic [NUM_REQ-1:0]  pick_gnt_s;
  logic [IDX_W-1:0]    pick_idx_s;
  logic                pick_found_s;
  logic                lock_ok_s;
  logic                rd_access_s;

  assign idx_inc_s = (idx_r == IDX_W'(NUM_REQ - 1)) ? '0 : (idx_r + IDX_W'(1));

  // While a grant is live the current owner is masked out and the search
  // starts just after it, so a release hands over without an idle bubble.
  assign pick_req_s = (state_r == ARB_IDLE) ? req : (req & ~gnt_r);
  assign pick_ptr_s = (state_r == ARB_IDLE) ? ptr_r : idx_inc_s;

  assign lock_ok_s = req_lock[idx_r] & req[idx_r] & (hold_cnt_r < HOLD_W'(LOCK_MAX - 1));

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req    (pick_req_s),
    .ptr    (pick_ptr_s),
    .grant  (pick_gnt_s),
    .winner (pick_idx_s),
    .found  (pick_found_s)
  );

  // Next-state logic: grant issue, lock extension, release and hand-over.
  always_comb begin
    state_s   = state_r;
    gnt_s     = gnt_r;
    idx_s     = idx_r;
    ptr_s     = ptr_r;
    hold_s    = hold_cnt_r;
    timeout_s = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        if (pick_found_s) begin
          state_s = ARB_GRANT;
          gnt_s   = pick_gnt_s;
          idx_s   = pick_idx_s;
        end else begin
          state_s = ARB_IDLE;
          gnt_s   = '0;
        end
      end
      ARB_GRANT, ARB_LOCKED: begin
        if (lock_ok_s) begin
          state_s = ARB_LOCKED;
          hold_s  = sat_inc(hold_cnt_r);
        end else begin
          // A lock still asked for here can only mean the hold limit was hit.
          timeout_s = req_lock[idx_r] & req[idx_r];
          ptr_s     = idx_inc_s;
          hold_s    = '0;
          if (pick_found_s) begin
            state_s = ARB_GRANT;
            gnt_s   = pick_gnt_s;
            idx_s   = pick_idx_s;
          end else begin
            state_s = ARB_IDLE;
            gnt_s   = '0;
          end
        end
      end
      default: begin
        state_s = ARB_IDLE;
        gnt_s   = '0;
        hold_s  = '0;
      end
    endcase
  end

  // RAM port mux: the owner drives the port, an access needs req still high.
  always_comb begin
    if (|gnt_r) begin
      mem_addr    = req_addr[idx_r*ADDR_WIDTH +: ADDR_WIDTH];
      mem_wdata   = req_wdata[idx_r*DATA_WIDTH +: DATA_WIDTH];
      mem_we      = req_we[idx_r] & req[idx_r];
      rd_access_s = ~req_we[idx_r] & req[idx_r];
    end else begin
      mem_addr    = '0;
      mem_wdata   = '0;
      mem_we      = 1'b0;
      rd_access_s = 1'b0;
    end
  end

  // State, grant, bookkeeping and read-return registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ARB_IDLE;
      gnt_r          <= '0;
      idx_r          <= '0;
      ptr_r          <= '0;
      hold_cnt_r     <= '0;
      lock_timeout_r <= 1'b0;
      rvalid_r       <= '0;
    end else begin
      state_r        <= state_s;
      gnt_r          <= gnt_s;
      idx_r          <= idx_s;
      ptr_r          <= ptr_s;
      hold_cnt_r     <= hold_s;
      lock_timeout_r <= timeout_s;
      rvalid_r       <= rd_access_s ? gnt_r : '0;
    end
  end

  assign gnt          = gnt_r;
  assign rvalid       = rvalid_r;
  assign lock_timeout = lock_timeout_r;
  // The synchronous RAM already delivers the word in the strobe cycle.
  assign rdata        = (|rvalid_r) ? mem_rdata : '0;

endmodule

// File: doc/sprite_mem_arbiter.md
# sprite_mem_arbiter

Arbitrates the single port of the sprite attribute RAM among up to NUM_REQ sprite controllers (movement, animation, collision). Each requester issues one-word read or write requests through a req/gnt handshake. A requester can hold the port across a fetch→save read-modify-write with `lock`. The arbiter uses registered round-robin grants, returns read data with fixed latency, and force-releases any lock held for more than LOCK_MAX cycles.

## Interface
- DATA_WIDTH, 16, RAM word width
- ADDR_WIDTH, 16, RAM address width
- NUM_REQ, 4, number of requesters (2..8)
- LOCK_MAX, 8, maximum consecutive grant cycles for one requester
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req  in  NUM_REQ  per-requester access request; hold until granted
- req_lock  in  NUM_REQ  keep grant after the current cycle
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data, same packing
- gnt  out  NUM_REQ  one-hot or zero; registered
- rdata  out  DATA_WIDTH  read data, valid when any rvalid bit is set
- rvalid  out  NUM_REQ  one-hot read-return strobe
- lock_timeout  out  1  one-cycle pulse when a lock is force-released
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_wdata  out  DATA_WIDTH  RAM write data
- mem_we  out  1  RAM write enable
- mem_rdata  in  DATA_WIDTH  RAM read data; synchronous, valid 1 cycle after address

## Operation
- States:
  - IDLE: gnt = 0.
  - GRANT: single-cycle grant.
  - LOCKED: grant held because req_lock was seen.
- Winner selection:
  - Search order starts at `ptr` and wraps modulo NUM_REQ.
  - The winner is the first i with req[i].
  - After a grant to i is released, `ptr` = (i+1) mod NUM_REQ.
- IDLE → GRANT: any req bit set. gnt[winner] is asserted next cycle.
- GRANT(i) / LOCKED(i), decided in each granted cycle:
  - req_lock[i] && req[i] && hold_cnt < LOCK_MAX−1 → LOCKED(i), hold_cnt++.
  - Otherwise, if another requester is pending → GRANT(next winner), with no idle bubble.
  - Otherwise → IDLE.
- Access gating:
  - The access happens only in a cycle with gnt[i] && req[i].
  - If req[i] drops during its grant cycle, the access is cancelled: mem_we = 0 and no rvalid.
  - The grant still ends normally.
- Port mux:
  - While gnt[i]: mem_addr/mem_wdata = slice i, mem_we = req_we[i] & req[i].
  - With no grant: mem_addr = 0, mem_wdata = 0, mem_we = 0.
- Read return: for a read access by i in cycle t, rvalid[i] = 1 and rdata = mem_rdata in cycle t+1.
- Lock timeout:
  - In the LOCK_MAX-th consecutive grant cycle to i, the grant is released regardless of req_lock.
  - lock_timeout pulses in the following cycle.
  - ptr moves to i+1.
  - hold_cnt clears on every release.
- hold_cnt is clog2(LOCK_MAX)+1 bits wide and saturates; it never wraps.

## Timing
- Reset values: gnt = 0, rvalid = 0, rdata = 0, lock_timeout = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, ptr = 0, hold_cnt = 0, state = IDLE.
- Latency:
  - req rising in cycle t (port idle) → gnt in t+1.
  - Read data/rvalid in t+2.
- Back-to-back grants to different requesters occur on consecutive cycles.
- Simultaneous requests: ptr order decides; other requesters wait, req held.
- Reset mid-LOCKED:
  - All outputs return to reset values in the next cycle.
  - A read in flight is dropped; no rvalid.
- Requesters sample gnt combinationally from the registered output. A requester holding lock issues its next access in the following granted cycle.

## Structure
- Shared package `sprite_mem_pkg` holds:
  - Attribute addresses: SPRITE_X = 'h1000, SPRITE_Y = 'h1001, SPRITE_FRAME = 'h1002.
  - Frame codes: STANDING = 0, WALK_START = 1, WALK_MID = 2, WALK_END = 3.
  - Arbiter state encoding.
- Sub-module `rr_pick`: combinational round-robin winner from (req, ptr).
  - Outputs: one-hot grant and winner index.
  - Instantiated once.
- The arbiter module holds the FSM, ptr, hold_cnt, port mux, and rvalid pipeline.

## Test plan
- Single read: req[0], addr 'h1000, RAM holds 120 → gnt[0] at t+1; rvalid[0] at t+2 with rdata = 120.
- Read-modify-write under lock:
  - req[1] with lock reads 'h1002 (value 2), then writes 3 without lock.
  - Expect gnt[1] in two consecutive cycles and mem_we only in the second.
  - No other requester is granted between the two cycles.
- Fairness: req = 4'b1111 held for 8 cycles → gnt sequence 0,1,2,3,0,1,2,3 with no gaps.
- Lock timeout:
  - req[2] and lock[2] held forever, req[3] pending.
  - Expect gnt[2] for exactly 8 cycles, lock_timeout pulse, then gnt[3].
- Cancelled access: req[0] drops during its gnt cycle → mem_we = 0, no rvalid, next pending requester granted the following cycle.
- Reset while LOCKED with a read in flight → next cycle gnt = 0, rvalid = 0; first post-reset grant goes to requester 0.
